ccu_timer: RTL and testbench
============================

Name: ccu_timer

Overview:
Interval timer feeding the crossing control unit's `proceed` input.
- Restarts on the CCU's `tr` pulse.
- Times a phase whose length is set by the CCU's `multiplier` output.
- Emits a single-cycle `proceed` pulse when the phase expires, which advances the CCU state machine.
- Contains a clock prescaler and a phase tick counter, so the CCU itself stays timing-free.

Parameters:
- PRESCALE, 1000, clk cycles per timer tick; legal range >= 1.
- UNIT_TICKS, 5, ticks per multiplier step; legal range >= 1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- tr  input  1  restart pulse from CCU; samples `multiplier` and starts a new phase.
- multiplier  input  2  phase length select; sampled only in a cycle where tr=1.
- hold  input  1  freezes the running timer while 1.
- proceed  output  1  one-cycle pulse at phase expiry; drives CCU proceed.
- busy  output  1  1 while a phase is being timed.

Behaviour:
- Reset (reset=0, asynchronous):
  - proceed=0, busy=0.
  - Prescaler and tick counter cleared.
  - State IDLE.
  - Takes effect immediately, mid-phase included; no pulse is generated on release.
- Phase length: D = (multiplier+1)*UNIT_TICKS ticks.
  - multiplier 00/01/10/11 gives 1x/2x/3x/4x UNIT_TICKS.
  - Counter widths: $clog2(PRESCALE) for the prescaler, $clog2(4*UNIT_TICKS+1) for ticks; no overflow is possible.
- States:
  - IDLE: busy=0. tr=1 -> load prescaler=PRESCALE-1 and ticks=D-1, go RUN.
  - RUN: busy=1.
    - Each non-held cycle the prescaler decrements.
    - At prescaler=0 it reloads PRESCALE-1 and ticks decrements.
    - At prescaler=0 and ticks=0: next cycle proceed=1 and the state returns to IDLE.
- Latency: with tr sampled at edge k and no hold, proceed is high in exactly the one cycle following edge k+D*PRESCALE.
- hold=1 freezes both counters in RUN; expiry is delayed by exactly the number of held cycles. hold is ignored in IDLE.
- tr=1 during RUN restarts the phase with a fresh `multiplier` sample, with no pulse for the aborted phase.
- tr=1 in the same cycle as expiry: restart wins, proceed stays 0, busy stays 1.
- tr=1 in the cycle proceed=1 (CCU response): normal restart, with proceed=1 for that cycle only.
- proceed is never high for two consecutive cycles. No pulse is emitted from IDLE without tr.
- hold and tr together in RUN: restart happens and counters load; hold applies from the next cycle.
- PRESCALE=1: a tick every cycle, so D cycles latency.

Optional Feature:
- Macro: CCU_TIMER_REMAIN_EN.
- Defined: adds output `remaining` [$clog2(4*UNIT_TICKS+1)-1:0].
  - Equals ticks+1 in RUN; 0 in IDLE and on reset.
  - Registered, updating in the same cycle as the tick counter; intended for a countdown display.
- Undefined: no port and no extra logic; all other behaviour identical.

Test Plan:
- PRESCALE=2, UNIT_TICKS=3; reset release; tr=1 one cycle with multiplier=01 -> busy=1 next cycle; proceed=1 exactly once, 12 cycles after the tr edge; busy=0 after.
- Same params, multiplier=11 -> proceed after 24 cycles; multiplier=00 -> proceed after 6 cycles.
- multiplier=01, hold=1 for 5 cycles mid-phase -> proceed at 17 cycles instead of 12; remaining (if REMAIN_EN) frozen during hold.
- tr at cycle 0 (mult=11), second tr at cycle 10 (mult=00) -> no pulse at cycle 24; single proceed at cycle 16.
- tr asserted exactly in the expiry cycle -> proceed stays 0, busy stays 1, new phase completes D*PRESCALE cycles later.
- reset=0 asynchronously mid-RUN -> proceed=0 and busy=0 immediately without a clock edge; after release, no proceed until tr.

Source files
------------

// File: rtl/ccu_timer.sv
// Interval timer for the crossing control unit: a tr pulse starts a phase of (multiplier+1)*UNIT_TICKS ticks,
// each tick being PRESCALE clocks, and a one-cycle proceed pulse marks expiry. Optional macro: CCU_TIMER_REMAIN_EN.
module ccu_timer #(
    parameter int PRESCALE   = 1000,
    parameter int UNIT_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tr,
    input  logic [1:0] multiplier,
    input  logic       hold,
    output logic       proceed,
    output logic       busy
`ifdef CCU_TIMER_REMAIN_EN
    ,
    output logic [$clog2(4*UNIT_TICKS+1)-1:0] remaining
`endif
);

    // A PRESCALE of 1 would give a zero-width prescaler, so keep at least one bit.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TW = $clog2(4*UNIT_TICKS+1);
    localparam logic [PW-1:0] PRESC_RELOAD = PW'(PRESCALE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] ticks_q, ticks_d;
    logic          proceed_q, proceed_d;
    logic [TW-1:0] phase_ticks;

    assign phase_ticks = TW'((int'(multiplier) + 1) * UNIT_TICKS - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            ticks_q   <= '0;
            proceed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            ticks_q   <= ticks_d;
            proceed_q <= proceed_d;
        end
    end

    // A restart always takes priority over hold and over expiry of the current phase.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        ticks_d   = ticks_q;
        proceed_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tr) begin
                    state_d = RUN;
                    presc_d = PRESC_RELOAD;
                    ticks_d = phase_ticks;
                end
            end
            RUN: begin
                if (tr) begin
                    presc_d = PRESC_RELOAD;
                    ticks_d = phase_ticks;
                end else if (!hold) begin
                    if (presc_q == '0) begin
                        if (ticks_q == '0) begin
                            state_d   = IDLE;
                            proceed_d = 1'b1;
                        end else begin
                            presc_d = PRESC_RELOAD;
                            ticks_d = ticks_q - TW'(1);
                        end
                    end else begin
                        presc_d = presc_q - PW'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == RUN);
        proceed = proceed_q;
    end

`ifdef CCU_TIMER_REMAIN_EN
    logic [TW-1:0] remaining_q, remaining_d;

    always_comb begin
        remaining_d = (state_d == RUN) ? (ticks_d + TW'(1)) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

    assign remaining = remaining_q;
`endif

endmodule

// File: tb/tb_ccu_timer.sv
// Bench for ccu_timer: directed and random steps checked every cycle against a deadline-based reference model.
module tb_ccu_timer;

    localparam int P  = 2;
    localparam int U  = 3;
    localparam int TW = $clog2(4*U+1);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tr = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] multiplier = 2'b00;
    logic       proceed;
    logic       busy;
`ifdef CCU_TIMER_REMAIN_EN
    logic [TW-1:0] remaining;
`endif

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int deadline = 0;
    bit running = 1'b0;
    bit exp_proceed = 1'b0;

    ccu_timer #(.PRESCALE(P), .UNIT_TICKS(U)) dut (
        .clk        (clk),
        .reset      (reset),
        .tr         (tr),
        .multiplier (multiplier),
        .hold       (hold),
        .proceed    (proceed),
        .busy       (busy)
`ifdef CCU_TIMER_REMAIN_EN
        ,
        .remaining  (remaining)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check_bit("proceed", proceed, exp_proceed);
        check_bit("busy", busy, running);
`ifdef CCU_TIMER_REMAIN_EN
        check_val("remaining", int'(remaining), running ? (deadline - cyc + P - 1) / P : 0);
`endif
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after it.
    // The model keeps an absolute expiry cycle; each held cycle pushes it out by one.
    task automatic step(input logic t, input logic [1:0] m, input logic h);
        tr = t;
        multiplier = m;
        hold = h;
        @(posedge clk);
        cyc++;
        exp_proceed = 1'b0;
        if (!reset) begin
            running = 1'b0;
        end else if (t) begin
            running = 1'b1;
            deadline = cyc + (int'(m) + 1) * U * P;
        end else if (running) begin
            if (h) deadline++;
            if (cyc == deadline) begin
                exp_proceed = 1'b1;
                running = 1'b0;
            end
        end
        #1;
        tr = 1'b0;
        hold = 1'b0;
        $display("[TB] cycle %0d tr=%b mult=%0d hold=%b -> proceed=%b busy=%b", cyc, t, m, h, proceed, busy);
        check_outputs();
    endtask

    initial begin
        #1;
        check_bit("reset_proceed", proceed, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        repeat (4) step(1'b0, 2'b00, 1'b0);           // idle: no spontaneous pulse

        step(1'b1, 2'b01, 1'b0);                      // 12-cycle phase
        repeat (14) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b11, 1'b0);                      // 24-cycle phase
        repeat (26) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);                      // 6-cycle phase
        repeat (8) step(1'b0, 2'b00, 1'b0);

        step(1'b1, 2'b01, 1'b0);                      // hold 5 cycles mid-phase
        repeat (4) step(1'b0, 2'b00, 1'b0);
        repeat (5) step(1'b0, 2'b00, 1'b1);
        repeat (12) step(1'b0, 2'b00, 1'b0);

        step(1'b1, 2'b11, 1'b0);                      // restart at cycle 10 with shorter phase
        repeat (9) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        repeat (20) step(1'b0, 2'b00, 1'b0);

        step(1'b1, 2'b00, 1'b0);                      // tr coincides with expiry edge
        repeat (5) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b01, 1'b0);
        repeat (14) step(1'b0, 2'b00, 1'b0);

        step(1'b1, 2'b00, 1'b0);                      // tr in the proceed cycle
        repeat (6) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        repeat (8) step(1'b0, 2'b00, 1'b0);

        step(1'b1, 2'b10, 1'b0);                      // tr with hold while running, hold in idle
        repeat (3) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b1);
        repeat (3) step(1'b0, 2'b00, 1'b1);
        repeat (10) step(1'b0, 2'b00, 1'b0);
        repeat (3) step(1'b0, 2'b00, 1'b1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end
        repeat (30) step(1'b0, 2'b00, 1'b0);

        step(1'b1, 2'b11, 1'b0);                      // asynchronous reset mid-phase
        repeat (5) step(1'b0, 2'b00, 1'b0);
        #2 reset = 1'b0;
        #1;
        running = 1'b0;
        exp_proceed = 1'b0;
        check_bit("async_rst_proceed", proceed, 1'b0);
        check_bit("async_rst_busy", busy, 1'b0);
        repeat (2) step(1'b0, 2'b00, 1'b0);
        reset = 1'b1;
        repeat (30) step(1'b0, 2'b00, 1'b0);
        step(1'b1, 2'b00, 1'b0);
        repeat (8) step(1'b0, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
